// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag bit positions and FSM state encoding shared by alu_seq
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle of alu_seq
//   master: drives in_valid, a, b, op, shamt, out_ready; sees in_ready, out_valid, result, flags, busy
//   slave : the ALU side, directions mirrored
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, a, b, op, shamt, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );
    modport slave (
        input  in_valid, a, b, op, shamt, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU for ops 000-101, returning result, carry/borrow and signed overflow
//   a, b : operands
//   op   : opcode (shift codes yield don't-care outputs)
//   y    : result; c : carry-out (ADD) or borrow (SUB); v : signed overflow
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = op == OP_ADD ? sum[WIDTH-1:0] :
            op == OP_SUB ? diff[WIDTH-1:0] :
            op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b : ~a;
        // the extra top bit of the widened subtraction is the borrow
        c = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? diff[WIDTH] : 1'b0;
        v = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
            op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes, Z/N/C/V flags and bit-serial shifts
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : alu_seq_if slave (operands/opcode/shamt in, registered result/flags out, busy)
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;
    logic [SHW-1:0]   cnt;
    logic             shr_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] core_y;
    logic             core_c;
    logic             core_v;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             sh_right;
    logic             cout;
    logic             is_shift;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a  (bus.a),
        .b  (bus.b),
        .op (bus.op),
        .y  (core_y),
        .c  (core_c),
        .v  (core_v)
    );

    function automatic logic [3:0] mk_flags(logic [WIDTH-1:0] r, logic c, logic v);
        mk_flags         = '0;
        mk_flags[FLAG_Z] = r == '0;
        mk_flags[FLAG_N] = r[WIDTH-1];
        mk_flags[FLAG_C] = c;
        mk_flags[FLAG_V] = v;
    endfunction

    // the result register doubles as the shift working register; at accept the
    // first step is taken straight from operand a
    assign cur      = state == S_IDLE ? bus.a : res_q;
    assign sh_right = state == S_IDLE ? bus.op == OP_SHR : shr_q;
    assign nxt      = sh_right ? cur >> 1 : cur << 1;
    assign cout     = sh_right ? cur[0] : cur[WIDTH-1];
    assign is_shift = bus.op == OP_SHL || bus.op == OP_SHR;

    assign bus.in_ready  = state == S_IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            res_q       <= '0;
            flags_q     <= '0;
            cnt         <= '0;
            shr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    busy_q <= 1'b1;
                    if (!is_shift) begin
                        res_q       <= core_y;
                        flags_q     <= mk_flags(core_y, core_c, core_v);
                        state       <= S_HOLD;
                        out_valid_q <= 1'b1;
                    end else if (bus.shamt == '0) begin
                        res_q       <= bus.a;
                        flags_q     <= mk_flags(bus.a, 1'b0, 1'b0);
                        state       <= S_HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        res_q       <= nxt;
                        flags_q     <= mk_flags(nxt, cout, 1'b0);
                        cnt         <= bus.shamt - SHW'(1);
                        shr_q       <= bus.op == OP_SHR;
                        state       <= bus.shamt == SHW'(1) ? S_HOLD : S_SHIFT;
                        out_valid_q <= bus.shamt == SHW'(1);
                    end
                end
                S_SHIFT: begin
                    res_q   <= nxt;
                    flags_q <= mk_flags(nxt, cout, 1'b0);
                    cnt     <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state       <= S_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                S_HOLD: if (bus.out_ready) begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit sequential ALU with a valid/ready handshake on both input and output.
- Adds status flags (Z, N, C, V) and variable-amount shifts executed one bit per cycle.
- Keeps the 3-bit opcode map of the team's 8-bit combinational ALU.
- Sits between the register-file read stage and write-back. Results are registered and held until the consumer accepts them.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- SHW, $clog2(WIDTH), width of the shift-amount input.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored for NOT and shifts.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A, 111 SHR A (logical).
- shamt  in  SHW  shift amount for 110/111; ignored otherwise.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  {Z,N,C,V}, registered with result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low. Assertion forces state=IDLE, out_valid=0, result=0, flags=0, busy=0, shift counter=0.
- Reset mid-shift or mid-hold aborts the operation. The pending result is lost and nothing is emitted after release.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, shift in progress.
  - HOLD: in_ready=0, out_valid=1.
- Accept happens when in_valid && in_ready, sampled at the rising edge. Inputs are ignored in every other cycle, and operands are captured at accept.
- Non-shift ops (000-101):
  - Result and flags are computed and registered at the accept edge, and the next state is HOLD.
  - Latency is 1: out_valid is high in the cycle after accept.
- Shift ops, shamt=k:
  - k=0: result=a, C=0, go to HOLD. Latency 1.
  - k>=1: the accept edge loads the working register with a shifted by 1 and sets counter=k-1. If k=1, go to HOLD; otherwise go to SHIFT.
  - In SHIFT, each edge shifts by 1 and decrements the counter. The block leaves for HOLD on the edge where the counter goes 1->0.
  - out_valid rises exactly k cycles after accept.
  - SHL fills with 0 at the LSB. SHR fills with 0 at the MSB.
  - C = last bit shifted out (SHL: old MSB; SHR: old LSB).
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry-out. V = signed overflow (a, b same sign, result sign differs).
  - SUB: C = borrow (a < b unsigned). V = signed overflow (a, b signs differ, result sign differs from a).
  - AND/OR/XOR/NOT/shifts: V=0. Logic ops also have C=0.
- Z = (result == 0). N = result[WIDTH-1]. Both apply to all ops.
- HOLD:
  - result, flags and out_valid stay stable while out_ready=0; there is no timeout.
  - On out_valid && out_ready, the next state is IDLE. out_valid=0 and in_ready=1 in the following cycle.
  - result and flags keep their last values after handshake and are only overwritten at the next accept.
- Throughput is at most one op per 2 cycles. A new op cannot be accepted in the same cycle as the output handshake.
- busy = (state != IDLE), registered and consistent with the state.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams OP_ADD..OP_SHR.
  - Flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - State encoding S_IDLE, S_SHIFT, S_HOLD.
- Sub-module alu_core (combinational, WIDTH parameter) takes a, b, op and returns the result plus C/V for ops 000-101.
- The top level owns the FSM, the shift working register and counter, the flag registers and the handshake.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 -> out_valid one cycle after accept, result=0x80, flags Z0 N1 C0 V1.
- SUB a=0x00 b=0x01 -> result=0xFF, flags Z0 N1 C1 V0. SUB a=0x80 b=0x01 -> 0x7F with V=1.
- SHL a=0x81 shamt=3 -> out_valid exactly 3 cycles after accept, result=0x08, C=0, busy high for 3 cycles. SHR a=0x81 shamt=1 -> 0x40, C=1, latency 1. SHL shamt=0 -> result=a, C=0.
- Backpressure: XOR a=0xAA b=0xAA, out_ready low for 5 cycles -> result=0x00 with Z=1 held stable, in_ready=0 throughout, extra in_valid pulses ignored. Release out_ready -> in_ready=1 the cycle after handshake.
- Reset mid-shift: SHR shamt=7, assert rst_n=0 at cycle 3 -> out_valid, result and flags go to 0 immediately (asynchronously). No out_valid after release. The next op (AND 0xF0 & 0x3C = 0x30) completes normally.
- Back-to-back: 10 random ops with random out_ready -> results and flags match a reference model in order, with no drops or duplicates.
